// File: rtl/lc3_pkg.sv
// Shared encodings for the LC-3 MAR/address path: MARMUX source select and memory FSM states.
// Pure type/constant package; no logic, no latency, no flow control.
package lc3_pkg;

  typedef enum logic [1:0] {
    MARMUX_TRAPVECT = 2'd0,
    MARMUX_ADDR     = 2'd1,
    MARMUX_PC       = 2'd2,
    MARMUX_ZERO     = 2'd3
  } marmux_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } mem_state_e;

endpackage

// File: rtl/lc3_addr_sel.sv
// MARMUX source selector: trap vector (zero-extended), adder result, PC or zero.
// Purely combinational, zero latency, no backpressure.
module lc3_addr_sel
  import lc3_pkg::*;
#(
  parameter int W   = 16,
  parameter int TVW = 8
) (
  input  logic [1:0]     sel,
  input  logic [TVW-1:0] trapvect,
  input  logic [W-1:0]   addr_out,
  input  logic [W-1:0]   pc,
  output logic [W-1:0]   sel_dat
);

  always_comb begin
    sel_dat = '0;
    case (marmux_sel_e'(sel))
      MARMUX_TRAPVECT: sel_dat = {{(W-TVW){1'b0}}, trapvect};
      MARMUX_ADDR:     sel_dat = addr_out;
      MARMUX_PC:       sel_dat = pc;
      default:         sel_dat = '0;
    endcase
  end

endmodule

// File: rtl/lc3_mar_unit.sv
// LC-3 MARMUX bus driver, MAR register and single-outstanding memory request FSM with timeout.
// Request issues one cycle after mem_start; mem_start while busy is dropped (no queuing).
module lc3_mar_unit
  import lc3_pkg::*;
#(
  parameter int W       = 16,
  parameter int TVW     = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   marmux_sel,
  input  logic [W-1:0] ir,
  input  logic [W-1:0] addr_out,
  input  logic [W-1:0] pc,
  input  logic         gate_marmux,
  output logic [W-1:0] marmux_out,
  output logic         marmux_drive,
  input  logic [W-1:0] bus_in,
  input  logic         ld_mar,
  output logic [W-1:0] mar,
  input  logic         mem_start,
  input  logic         mem_we,
  output logic         mem_req,
  output logic         mem_we_o,
  output logic [W-1:0] mem_addr,
  input  logic         mem_ready,
  output logic         mem_done,
  output logic         mem_timeout,
  output logic         busy
);

  // TIMEOUT=0 still needs a 1-bit counter; it just saturates and is never compared.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  mem_state_e    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  sel_dat;
  logic          unused_ir;

  assign unused_ir = ^ir[W-1:TVW];

  lc3_addr_sel #(.W(W), .TVW(TVW)) u_addr_sel (
    .sel      (marmux_sel),
    .trapvect (ir[TVW-1:0]),
    .addr_out (addr_out),
    .pc       (pc),
    .sel_dat  (sel_dat)
  );

  // Undriven bus contribution must be zero, not X, for the wired-OR system bus.
  assign marmux_out   = gate_marmux ? sel_dat : '0;
  assign marmux_drive = gate_marmux;

  assign mem_req  = (state == ST_REQ);
  assign busy     = (state == ST_REQ);
  assign mem_addr = mar;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      mar         <= '0;
      mem_we_o    <= 1'b0;
      cnt         <= '0;
      mem_done    <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      mem_done    <= 1'b0;
      mem_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ld_mar) mar <= bus_in;
          if (mem_start) begin
            state    <= ST_REQ;
            mem_we_o <= mem_we;
            cnt      <= '0;
          end
        end
        ST_REQ: begin
          // Completion on the final allowed cycle beats the timeout.
          if (mem_ready) begin
            state    <= ST_IDLE;
            mem_done <= 1'b1;
          end else if ((TIMEOUT > 0) && (cnt == LAST)) begin
            state       <= ST_IDLE;
            mem_timeout <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
